serial_addsub_ctrl: RTL and testbench
=====================================

# serial_addsub_ctrl

Bit-serial add/subtract controller. It accepts two WIDTH-bit operands and an add/sub select, then streams one bit pair per clock, LSB first, through a single `one_bit_adder` cell. It holds the carry between bits in a flip-flop and assembles the result in a shift register. The block sits directly upstream of `one_bit_adder`, driving its `a`, `b`, `cin` and `op` inputs and consuming its `sum` and `cout` outputs. It trades area for latency in the lab ALU datapath.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 2.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a new operation; sampled only when the block is not busy.
- `op`, in, 1: 0 = add (a+b), 1 = subtract (a−b); captured with `start`.
- `a`, in, WIDTH: operand A; captured with `start`.
- `b`, in, WIDTH: operand B; captured with `start`.
- `busy`, out, 1: high while bits are being processed.
- `done`, out, 1: one-cycle pulse; `result`, `cout` and `overflow` are valid from this cycle on.
- `result`, out, WIDTH: a±b, modulo 2^WIDTH.
- `cout`, out, 1: final carry out (for subtract, 1 = no borrow).
- `overflow`, out, 1: signed overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- **FSM states:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE or DONE, `start`=1:**
  - Load `a_sr`←a, `b_sr`←b, `op_r`←op.
  - Set `carry`←op (two's-complement +1 for subtract).
  - Set `cnt`←0 and go to SHIFT.
- **IDLE, `start`=0:** stay in IDLE.
- **DONE, `start`=0:** go to IDLE.
- **SHIFT, each cycle:**
  - Cell inputs are a=`a_sr[0]`, b=`b_sr[0]`, cin=`carry`, op=`op_r`.
  - `a_sr` and `b_sr` shift right by one.
  - `res_sr` shifts right with the cell `sum` entering at bit WIDTH−1.
  - `carry`←cell `cout`; `cnt`←`cnt`+1.
  - When `cnt`==WIDTH−2, also latch `c_msb_in`←cell `cout` (this is the carry into the MSB).
  - When `cnt`==WIDTH−1, go to DONE.
- **Outputs:**
  - `result`=`res_sr`; `cout`=`carry`.
  - `overflow` = `c_msb_in` XOR `carry`, registered on the transition into DONE.
  - Outputs hold their values until the next accepted `start`.
- **Other rules:**
  - `start` in SHIFT is ignored; operands already loaded are unaffected.
  - `start` in the DONE cycle is accepted back-to-back, with no idle gap required.
  - `cnt` width is $clog2(WIDTH). It never wraps within an operation.
  - Reset mid-operation returns to IDLE immediately and clears all registers. The partial result is discarded.
- **Reset values:** `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0. Shift registers, `carry`, `cnt` and `op_r` are all 0.

## Timing
- Edge E0 samples `start`=1.
- `busy`=1 for exactly WIDTH cycles, following E0.
- `done`=1 for exactly one cycle, the (WIDTH+1)-th cycle after E0. `busy`=0 during that cycle.
- Total latency from start to result is WIDTH+1 cycles. Maximum throughput is one operation per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `one_bit_adder` is purely combinational between the registered `a_sr[0]`/`b_sr[0]`/`carry` and the next-state logic. There is one cell delay per cycle.

## Structure
- **Shared package `serial_alu_pkg`:**
  - FSM state encoding localparams: `S_IDLE`=2'd0, `S_SHIFT`=2'd1, `S_DONE`=2'd2.
  - `OP_ADD`=1'b0, `OP_SUB`=1'b1.
- **Sub-module:** exactly one instance of the existing `one_bit_adder` (ports a, b, cin, op, sum, cout). No other sub-modules.
- **Top-level contents:** FSM, counter, three shift registers, and the carry/overflow flops.

## Test plan
All scenarios use WIDTH=8.
1. Reset asserted mid-SHIFT (after 3 bits), released, then 10+20 → busy drops asynchronously at reset, no `done` pulse for the aborted operation; new operation gives `result`=30.
2. 25+17 → `result`=0x2A, `cout`=0, `overflow`=0; `done` exactly 9 cycles after the start edge; `busy` high 8 cycles.
3. 100+50 → `result`=0x96, `cout`=0, `overflow`=1.
4. 5−7 → `result`=0xFE, `cout`=0 (borrow), `overflow`=0.
5. 0x80−0x01 → `result`=0x7F, `cout`=1, `overflow`=1.
6. Two tests on `start` acceptance:
   - `start` pulsed with new operands during cycle 4 of SHIFT for 3+4 → ignored; `result`=7.
   - `start` held high through DONE for 1+1 then 2+2 → back-to-back operations yield 2 then 4, second `done` 9 cycles after first.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// ======================================================================
// serial_alu_pkg : shared FSM encoding and op codes for the serial ALU
// Rev 1.0
// ======================================================================
`default_nettype none

package serial_alu_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_ctrl_if.sv
// ======================================================================
// serial_addsub_ctrl_if : operand/result bundle of the serial add/sub block
// Rev 1.0
// ======================================================================
`default_nettype none

interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow
  );

endinterface

`default_nettype wire

// File: rtl/serial_addsub_ctrl_one_bit_adder.sv
// ======================================================================
// one_bit_adder : full adder cell with optional B inversion for subtract
// Rev 1.0
// ======================================================================
`default_nettype none

module one_bit_adder
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic sum,
  output logic cout
);

  logic b_eff;

  assign b_eff = (op == OP_ADD) ? b : ~b;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// ======================================================================
// serial_addsub_ctrl : bit-serial a+b / a-b through one full-adder cell
// Rev 1.0
// ======================================================================
`default_nettype none

module serial_addsub_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_addsub_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             op_q,     op_d;
  logic             carry_q,  carry_d;
  logic             c_msb_q,  c_msb_d;
  logic             ovf_q,    ovf_d;

  logic             cell_sum;
  logic             cell_cout;

  one_bit_adder u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          op_d    = bus.op;
          // Subtract seeds the carry with the +1 of two's complement.
          carry_d = (bus.op == OP_SUB);
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {cell_sum, res_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        if (cnt_q == CNT_MSB_IN) begin
          c_msb_d = cell_cout;
        end
        if (cnt_q == CNT_LAST) begin
          // c_msb_q was captured on an earlier edge, so it is stable here.
          ovf_d   = c_msb_q ^ cell_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.result   = res_sr_q;
  assign bus.cout     = carry_q;
  assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// ======================================================================
// tb_serial_addsub_ctrl : directed self-checking bench, WIDTH = 8
// Rev 1.0
// ======================================================================
`default_nettype none

module tb_serial_addsub_ctrl;
  import serial_alu_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   fails;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one rising edge (E0); returns just after E0.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic op);
    @(negedge clk);
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.op    = op;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
  endtask

  // Counts falling edges until done; lat = 0 means the bound expired.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic op, input logic [7:0] exp_res,
                               input logic exp_cout, input logic exp_ovf);
    int lat;
    int bc;
    issue(a, b, op);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, 9);
    check({tag, " busy cycles"}, bc, 8);
    check({tag, " result"}, bus_if.result, exp_res);
    check({tag, " cout"}, bus_if.cout, exp_cout);
    check({tag, " overflow"}, bus_if.overflow, exp_ovf);
    @(negedge clk);
    check({tag, " done one cycle"}, bus_if.done, 0);
    check({tag, " result held"}, bus_if.result, exp_res);
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    checks = 0;
    passes = 0;
    fails  = 0;
    bus_if.start = 1'b0;
    bus_if.op    = OP_ADD;
    bus_if.a     = '0;
    bus_if.b     = '0;
    rst_n        = 1'b0;

    repeat (2) @(negedge clk);
    check("rst busy", bus_if.busy, 0);
    check("rst done", bus_if.done, 0);
    check("rst result", bus_if.result, 0);
    check("rst cout", bus_if.cout, 0);
    check("rst overflow", bus_if.overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort an operation after three bits with an asynchronous reset.
    issue(8'hFF, 8'h01, OP_ADD);
    repeat (3) @(posedge clk);
    #2;
    check("abort busy before rst", bus_if.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy async", bus_if.busy, 0);
    check("abort result cleared", bus_if.result, 0);
    check("abort cout cleared", bus_if.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.done) done_seen++;
    end
    check("abort no done", done_seen, 0);
    run_and_check("10+20", 8'd10, 8'd20, OP_ADD, 8'd30, 1'b0, 1'b0);

    run_and_check("25+17", 8'd25, 8'd17, OP_ADD, 8'h2A, 1'b0, 1'b0);
    run_and_check("100+50", 8'd100, 8'd50, OP_ADD, 8'h96, 1'b0, 1'b1);
    run_and_check("5-7", 8'd5, 8'd7, OP_SUB, 8'hFE, 1'b0, 1'b0);
    run_and_check("80-01", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1, 1'b1);
    run_and_check("FF+01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0);

    // start pulsed during the 4th SHIFT cycle must be ignored.
    issue(8'd3, 8'd4, OP_ADD);
    repeat (4) @(negedge clk);
    bus_if.a     = 8'hFF;
    bus_if.b     = 8'hFF;
    bus_if.op    = OP_SUB;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    wait_done(lat, bc);
    check("mid-start latency", lat, 5);
    check("mid-start result", bus_if.result, 7);
    check("mid-start cout", bus_if.cout, 0);

    // start held high through DONE: back-to-back 1+1 then 2+2.
    @(negedge clk);
    bus_if.a     = 8'd1;
    bus_if.b     = 8'd1;
    bus_if.op    = OP_ADD;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.a = 8'd2;
    bus_if.b = 8'd2;
    wait_done(lat, bc);
    check("b2b first latency", lat, 9);
    check("b2b first result", bus_if.result, 2);
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    wait_done(lat, bc);
    check("b2b second latency", lat, 9);
    check("b2b second busy", bc, 8);
    check("b2b second result", bus_if.result, 4);
    @(negedge clk);
    check("b2b idle after", bus_if.busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
